// File: rtl/stream_fifo.sv
// stream_fifo: single-clock valid/ready FIFO built from a synchronous-read RAM
// followed by a two-entry output prefetch (RAM read register, output register),
// so the consumer always sees registered data at one word per cycle.
// Capacity MAX_DEPTH may be any value 2..2^ADDR_WIDTH; full/empty come from an
// explicit occupancy counter, never from pointer comparison.
// Optional feature: define STREAM_FIFO_PEAK_EN to build the high-water-mark
// register behind the peak output; otherwise peak is tied to zero.
module stream_fifo #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_DEPTH    = 1 << ADDR_WIDTH,
    parameter int AFULL_LEVEL  = MAX_DEPTH - 2,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   peak
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         MAX_CNT = CW'(MAX_DEPTH);
    localparam logic [CW-1:0]         AF_CNT  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0]         AE_CNT  = CW'(AEMPTY_LEVEL);
    localparam logic [CW-1:0]         CNT_ONE = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    // Storage and pointers
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    // Prefetch stages: p1 is the RAM read register, p2 is the output register
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;
    logic                  vld_p2;

    // Handshake and movement strobes
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  adv_p1;
    logic                  fetch;
    logic [CW-1:0]         ram_cnt;
    logic [CW-1:0]         count_nxt;

    // in_ready looks only at the registered count, so there is no
    // combinational path from in_valid or out_ready.
    assign in_ready     = (count < MAX_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign out_valid    = vld_p2;

    // A flush cycle discards any handshake that would otherwise fire.
    assign wr_fire = in_valid && in_ready && !flush;
    assign rd_fire = vld_p2 && out_ready && !flush;

    // p1 moves into the output register whenever that register is empty or
    // being emptied by the consumer this cycle.
    assign adv_p1 = vld_p1 && (!vld_p2 || rd_fire);

    // Words still sitting in RAM are those counted but not yet prefetched.
    assign ram_cnt = count - CW'(vld_p1) - CW'(vld_p2);

    // Fetch when RAM holds a word and p1 is free or is vacated this cycle;
    // a word written this edge is not visible in RAM until the next one.
    assign fetch = (ram_cnt != '0) && (!vld_p1 || adv_p1) && !flush;

    // Next occupancy: +1 on write only, -1 on read only
    always_comb begin
        count_nxt = count;
        if (wr_fire && !rd_fire) begin
            count_nxt = count + CNT_ONE;
        end else if (rd_fire && !wr_fire) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Control state: occupancy, pointers, stage valids, sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            overflow <= 1'b0;
        end else if (flush) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // p1 stays full if it is refilled in the same cycle it advances
            if (fetch) begin
                vld_p1 <= 1'b1;
            end else if (adv_p1) begin
                vld_p1 <= 1'b0;
            end
            if (adv_p1) begin
                vld_p2 <= 1'b1;
            end else if (rd_fire) begin
                vld_p2 <= 1'b0;
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---- stage boundary: producer -> RAM ----
    // RAM write port; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // ---- stage boundary: RAM -> p1 (synchronous read register) ----
    // RAM read register, loaded only when a fetch is issued
    always_ff @(posedge clk) begin
        if (fetch) begin
            data_p1 <= mem[rd_ptr];
        end
    end

    // ---- stage boundary: p1 -> p2 (output register) ----
    // Output register holds the head word stable until it is consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
        end else if (adv_p1) begin
            out_data <= data_p1;
        end
    end

`ifdef STREAM_FIFO_PEAK_EN
    logic [CW-1:0] peak_q;

    // Larger of the current mark and the candidate, clipped to capacity
    function automatic logic [CW-1:0] peak_sat(input logic [CW-1:0] cur,
                                               input logic [CW-1:0] cand);
        logic [CW-1:0] m;
        m = (cand > cur) ? cand : cur;
        return (m > MAX_CNT) ? MAX_CNT : m;
    endfunction

    // High-water mark follows the occupancy on the same edge; flush leaves it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q <= '0;
        end else if (!flush) begin
            peak_q <= peak_sat(peak_q, count_nxt);
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule
